// File: rtl/enc_pkg.sv
// Shared constants and types for the round-robin 4-to-2 encoder.
package enc_pkg;
    localparam int N_REQ  = 4;
    localparam int CODE_W = 2;
    localparam int CNT_W  = 8;

    typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/rr_pick4.sv
// Purpose: rotating-priority pick of one set request bit, starting the search at ptr.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick4
    import enc_pkg::*;
(
    input  logic [3:0] req,
    input  code_t      ptr,
    output code_t      pick,
    output logic       any,
    output logic       multi
);

    code_t idx;
    logic  found;

    always_comb begin
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        // Walk ptr, ptr+1, ptr+2, ptr+3; the 2-bit index wraps naturally.
        for (int i = 0; i < N_REQ; i++) begin
            idx = code_t'(ptr + code_t'(i));
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign any   = |req;
    assign multi = ($countones(req) > 1);

endmodule

// File: rtl/rr_encoder.sv
// Purpose: clocked 4-to-2 round-robin encoder with a one-entry valid/ready output register.
// Latency: req sampled at a clk edge appears on code/valid right after that edge (1 cycle).
// Backpressure: while valid=1 and ready=0 the output and pointer hold and req is ignored.
module rr_encoder
    import enc_pkg::*;
#(
    parameter int N_REQ  = enc_pkg::N_REQ,
    parameter int CODE_W = enc_pkg::CODE_W,
    parameter int CNT_W  = enc_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ready,
    output logic              multi,
    output logic [CNT_W-1:0]  count
);

    code_t ptr;
    code_t pick;
    logic  any;
    logic  pick_multi;
    logic  load;
    logic  accept;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .any   (any),
        .multi (pick_multi)
    );

    assign accept = valid && ready;
    assign load   = en && any && (!valid || ready);

    // Pointer moves on load rather than accept, so a back-to-back load sees the advanced pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code  <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
            ptr   <= '0;
        end else if (load) begin
            code  <= pick;
            multi <= pick_multi;
            valid <= 1'b1;
            ptr   <= pick + 1'b1;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (accept) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_encoder.sv
// Directed and random stimulus for rr_encoder, checked against a behavioural round-robin model.
module tb_rr_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [1:0] code;
    logic       valid;
    logic       ready;
    logic       multi;
    logic [7:0] count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_ptr, m_code, m_valid, m_multi, m_count;

    always #5 clk = ~clk;

    rr_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .code  (code),
        .valid (valid),
        .ready (ready),
        .multi (multi),
        .count (count)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".valid"}, int'(valid), m_valid);
        chk({tag, ".code"},  int'(code),  m_code);
        chk({tag, ".multi"}, int'(multi), m_multi);
        chk({tag, ".count"}, int'(count), m_count);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_code = 0; m_valid = 0; m_multi = 0; m_count = 0;
    endtask

    // One clock: apply inputs, advance the model by the behavioural rules, check after the edge.
    task automatic cycle(input logic [3:0] r, input logic e, input logic rd, input string tag);
        int  ones;
        bit  acc, ld;
        int  p;
        req = r; en = e; ready = rd;
        ones = 0;
        for (int b = 0; b < 4; b++) ones += int'(r[b]);
        acc = (m_valid == 1) && rd;
        ld  = e && (ones > 0) && ((m_valid == 0) || rd);
        if (acc) m_count = (m_count + 1) % 256;
        if (ld) begin
            p = -1;
            for (int k = 0; k < 4; k++)
                if (p < 0 && r[(m_ptr + k) % 4]) p = (m_ptr + k) % 4;
            m_code  = p;
            m_multi = (ones > 1) ? 1 : 0;
            m_valid = 1;
            m_ptr   = (p + 1) % 4;
        end else if (acc) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req = 4'b0; ready = 1'b0;
        model_reset();
        #3;
        chk_all("reset");
        @(posedge clk); #1;
        chk_all("reset_hold");
        rst_n = 1'b1;

        // Single request
        cycle(4'b0100, 1'b1, 1'b1, "single");
        chk("single.code_is_2", int'(code), 2);
        cycle(4'b0001, 1'b1, 1'b1, "single_wrap_search");
        chk("search_from_3", int'(code), 0);

        // Round robin with all requests held
        for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b1, 1'b1, "rr_all");
        chk("rr_multi", int'(multi), 1);

        // Backpressure: hold while req changes
        cycle(4'b0010, 1'b1, 1'b1, "bp_load");
        chk("bp_code1", int'(code), 1);
        for (int i = 0; i < 3; i++) cycle(4'b1000, 1'b1, 1'b0, "bp_hold");
        chk("bp_still1", int'(code), 1);
        cycle(4'b1000, 1'b1, 1'b1, "bp_release");
        chk("bp_next3", int'(code), 3);

        // Enable low: pending transfer drains, nothing new loads
        cycle(4'b0001, 1'b0, 1'b0, "en_hold");
        cycle(4'b0001, 1'b0, 1'b1, "en_drain");
        chk("en_drained", int'(valid), 0);
        for (int i = 0; i < 3; i++) cycle(4'b0001, 1'b0, 1'b1, "en_idle");
        cycle(4'b0001, 1'b1, 1'b1, "en_resume");

        // req=0 with ready drops valid
        cycle(4'b0000, 1'b1, 1'b1, "req_zero");
        chk("req_zero_valid", int'(valid), 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 3) != 0), "random");

        // Asynchronous reset mid-transfer
        cycle(4'b1010, 1'b1, 1'b0, "pre_reset");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        #2;
        rst_n = 1'b1;
        req = 4'b0; ready = 1'b0;

        // Counter wrap: 256 accepts from reset
        cycle(4'b1111, 1'b1, 1'b1, "wrap_first_load");
        for (int i = 0; i < 256; i++) cycle(4'b1111, 1'b1, 1'b1, "wrap");
        chk("wrap_count_zero", int'(count), 0);
        cycle(4'b0000, 1'b1, 1'b1, "wrap_drop");
        chk("wrap_valid_low", int'(valid), 0);
        chk("wrap_count_one", int'(count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
